// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the FSM state encoding, the tag base byte and the frame-length formula.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ISSUE_TAG,
        WAIT_TAG
    } arb_state_t;

    localparam logic [7:0] TAG_BASE = 8'hA0;

    // Ten bit periods of (baud count + 1) cycles each, plus an idle guard gap.
    function automatic int frame_cycles(input int clk_freq, input int bps, input int guard);
        return (clk_freq / bps + 1) * 10 + guard;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from ptr+1,
// wrapping modulo REQ_NUM.
module uart_rr_pick #(
    parameter int REQ_NUM = 4,
    localparam int IDW = $clog2(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [REQ_NUM-1:0] grant,
    output logic [IDW-1:0]     idx,
    output logic               any_req
);

    logic [IDW-1:0] cand;

    always_comb begin
        grant   = '0;
        idx     = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int k = 1; k <= REQ_NUM; k++) begin
            cand = IDW'((int'(ptr) + k) % REQ_NUM);
            if (!any_req && req[cand]) begin
                any_req     = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter, paced by a frame-length timer.
// Define UART_ARB_TAG_EN to precede every granted byte with an 8'hA0|grant_id tag frame.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int REQ_NUM      = 4,
    parameter int UART_BPS     = 9600,
    parameter int CLK_FREQ     = 50_000_000,
    parameter int GUARD_CYCLES = 16,
    localparam int IDW = $clog2(REQ_NUM)
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [REQ_NUM-1:0]   req_valid,
    input  logic [8*REQ_NUM-1:0] req_data,
    output logic [REQ_NUM-1:0]   req_ack,
    output logic [7:0]           tx_data,
    output logic                 tx_flag,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id
);

    localparam int FRAME_CYCLES = frame_cycles(CLK_FREQ, UART_BPS, GUARD_CYCLES);
    localparam int TW           = $clog2(FRAME_CYCLES + 1);

    logic [7:0] req_bytes [REQ_NUM];

    for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_unpack
        assign req_bytes[gi] = req_data[8*gi +: 8];
    end

    logic [REQ_NUM-1:0] pick_onehot;
    logic [IDW-1:0]     pick_idx;
    logic               pick_any;

    arb_state_t         state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [IDW-1:0]     grant_q, grant_d;
    logic [REQ_NUM-1:0] ack_q, ack_d;
    logic               flag_q, flag_d;
    logic               busy_q, busy_d;
`ifdef UART_ARB_TAG_EN
    logic [7:0]         hold_q, hold_d;
`endif

    uart_rr_pick #(
        .REQ_NUM (REQ_NUM)
    ) u_pick (
        .req     (req_valid),
        .ptr     (ptr_q),
        .grant   (pick_onehot),
        .idx     (pick_idx),
        .any_req (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        timer_d   = timer_q;
        tx_data_d = tx_data_q;
        grant_d   = grant_q;
        ack_d     = '0;
        flag_d    = 1'b0;
        busy_d    = busy_q;
`ifdef UART_ARB_TAG_EN
        hold_d    = hold_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    ptr_d   = pick_idx;
                    grant_d = pick_idx;
                    ack_d   = pick_onehot;
                    busy_d  = 1'b1;
`ifdef UART_ARB_TAG_EN
                    hold_d    = req_bytes[pick_idx];
                    tx_data_d = TAG_BASE | 8'(pick_idx);
                    state_d   = ISSUE_TAG;
`else
                    tx_data_d = req_bytes[pick_idx];
                    state_d   = ISSUE;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            ISSUE_TAG: begin
                flag_d  = 1'b1;
                timer_d = TW'(FRAME_CYCLES - 1);
                state_d = WAIT_TAG;
            end
            WAIT_TAG: begin
                // The payload byte is presented only after the tag frame has fully elapsed.
                if (timer_q == '0) begin
                    tx_data_d = hold_q;
                    state_d   = ISSUE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
`endif
            ISSUE: begin
                flag_d  = 1'b1;
                timer_d = TW'(FRAME_CYCLES - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (timer_q == '0) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            ptr_q     <= IDW'(REQ_NUM - 1);
            timer_q   <= '0;
            tx_data_q <= 8'h00;
            grant_q   <= '0;
            ack_q     <= '0;
            flag_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_ARB_TAG_EN
            hold_q    <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            timer_q   <= timer_d;
            tx_data_q <= tx_data_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            flag_q    <= flag_d;
            busy_q    <= busy_d;
`ifdef UART_ARB_TAG_EN
            hold_q    <= hold_d;
`endif
        end
    end

    assign req_ack  = ack_q;
    assign tx_data  = tx_data_q;
    assign tx_flag  = flag_q;
    assign busy     = busy_q;
    assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, hand sequences and a
// randomized queue-level round-robin reference model.
module tb_uart_tx_arbiter;

    localparam int NREQ  = 4;
    localparam int CLK_F = 1_000_000;
    localparam int BPS   = 200_000;
    localparam int GUARD = 4;
    localparam int F     = (CLK_F / BPS + 1) * 10 + GUARD;
`ifdef UART_ARB_TAG_EN
    localparam int BUSY_CYC = 2 * F + 2;
    localparam int NFLAGS   = 2;
    localparam int PERIOD   = 2 * F + 3;
`else
    localparam int BUSY_CYC = F + 1;
    localparam int NFLAGS   = 1;
    localparam int PERIOD   = F + 2;
`endif
    localparam int BOUND = 4 * F + 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [8*NREQ-1:0]   req_data = '0;
    logic [NREQ-1:0]     req_ack;
    logic [7:0]          tx_data;
    logic                tx_flag;
    logic                busy;
    logic [1:0]          grant_id;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int model_ptr = NREQ - 1;

    uart_tx_arbiter #(
        .REQ_NUM      (NREQ),
        .UART_BPS     (BPS),
        .CLK_FREQ     (CLK_F),
        .GUARD_CYCLES (GUARD)
    ) dut (
        .sys_clk   (clk),
        .sys_rst   (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ack   (req_ack),
        .tx_data   (tx_data),
        .tx_flag   (tx_flag),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Protocol monitor: ack shape and data stability during a frame.
    logic [NREQ-1:0] prev_ack;
    logic            prev_busy;
    logic [7:0]      prev_data;
    always @(negedge clk) begin
        if (rst) begin
            prev_ack  <= '0;
            prev_busy <= 1'b0;
            prev_data <= 8'h00;
        end else begin
            if (req_ack != '0) begin
                check("m_onehot", 32'($countones(req_ack)), 32'd1);
                check("m_ack_gap", 32'(prev_ack), 32'd0);
            end
`ifndef UART_ARB_TAG_EN
            if (busy && prev_busy) check("m_hold", 32'(tx_data), 32'(prev_data));
`endif
            prev_ack  <= req_ack;
            prev_busy <= busy;
            prev_data <= tx_data;
        end
    end

    // Waits for one ack, then follows the frame(s) until busy drops.
    task automatic run_grant(input string nm, input int id, input logic [7:0] b,
                             input bit drop, output int lat, output int ack_cyc);
        int bc, nfl, off0, off1;
        logic [7:0] d0, d1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (req_ack == '0 && lat < BOUND);
        ack_cyc = cyc;
        check({nm, "_ack"}, 32'(req_ack), 32'(1 << id));
        check({nm, "_gid"}, 32'(grant_id), 32'(id));
        $display("[TB] %s: ack=%b grant_id=%0d cycle=%0d", nm, req_ack, grant_id, cyc);
        if (drop) req_valid = '0;
        bc = 0; nfl = 0; off0 = -1; off1 = -1; d0 = 8'h00; d1 = 8'h00;
        while (busy && bc < BOUND) begin
            if (tx_flag) begin
                if (nfl == 0) begin off0 = bc; d0 = tx_data; end
                else begin off1 = bc; d1 = tx_data; end
                nfl++;
            end
            bc++;
            @(negedge clk);
        end
        check({nm, "_busy_len"}, 32'(bc), 32'(BUSY_CYC));
        check({nm, "_nflags"}, 32'(nfl), 32'(NFLAGS));
        check({nm, "_flag_lat"}, 32'(off0), 32'd1);
`ifdef UART_ARB_TAG_EN
        check({nm, "_tag"}, 32'(d0), 32'(8'hA0 | 8'(id)));
        check({nm, "_flag2_off"}, 32'(off1), 32'(F + 2));
        check({nm, "_data"}, 32'(d1), 32'(b));
`else
        check({nm, "_data"}, 32'(d0), 32'(b));
`endif
        if (drop) begin
            @(negedge clk);
            check({nm, "_quiet"}, {23'd0, req_ack, tx_flag, 4'd0}, 32'd0);
        end
    endtask

    // Randomized round: each requester gets 0..3 queued bytes, all presented at once.
    task automatic random_round(input int r);
        logic [7:0] bytes_a [NREQ][4];
        int len [NREQ];
        int head [NREQ];
        int mh [NREQ];
        int exp_q [$];
        logic [7:0] pend_q [$];
        logic [NREQ-1:0] glmask;
        int last, tot, got, n, id, k, extra;
        tot = 0;
        for (int i = 0; i < NREQ; i++) begin
            len[i] = $urandom_range(0, 3);
            head[i] = 0;
            mh[i] = 0;
            for (int j = 0; j < 4; j++) bytes_a[i][j] = 8'($urandom);
            tot += len[i];
        end
        // Reference: serve non-empty queues in round-robin order after the last winner.
        last = model_ptr;
        for (int t = 0; t < tot; t++) begin
            for (int s = 1; s <= NREQ; s++) begin
                int c;
                c = (last + s) % NREQ;
                if (mh[c] < len[c]) begin
                    exp_q.push_back(c);
                    mh[c]++;
                    last = c;
                    break;
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = (len[i] > 0);
            req_data[8*i +: 8] = bytes_a[i][0];
        end
        got = 0; n = 0; glmask = '0;
        while (got < tot && n < BOUND * (tot + 1)) begin
            @(negedge clk);
            n++;
            req_valid = req_valid & ~glmask;
            glmask = '0;
            if (tx_flag) begin
                if (pend_q.size() == 0) check("r_flag_extra", 32'd1, 32'd0);
                else check("r_flag_data", 32'(tx_data), 32'(pend_q.pop_front()));
            end
            if (req_ack != '0) begin
                id = 0;
                for (int i = 0; i < NREQ; i++) if (req_ack[i]) id = i;
                check("r_ack_id", 32'(id), 32'(exp_q[got]));
                check("r_gid", 32'(grant_id), 32'(exp_q[got]));
                $display("[TB] rnd%0d: ack id=%0d byte=%02h cycle=%0d", r, id,
                         bytes_a[id][head[id] % 4], cyc);
`ifdef UART_ARB_TAG_EN
                pend_q.push_back(8'hA0 | 8'(id));
`endif
                pend_q.push_back(bytes_a[id][head[id] % 4]);
                if (head[id] < len[id]) head[id]++;
                req_valid[id] = (head[id] < len[id]);
                req_data[8*id +: 8] = bytes_a[id][head[id] % 4];
                got++;
            end else if (busy && $urandom_range(0, 5) == 0) begin
                // One-cycle pulse from an idle requester while busy: must never be served.
                k = $urandom_range(0, NREQ - 1);
                if (head[k] >= len[k]) begin
                    glmask[k] = 1'b1;
                    req_valid[k] = 1'b1;
                    req_data[8*k +: 8] = 8'($urandom);
                end
            end
        end
        req_valid = req_valid & ~glmask;
        check("r_served", 32'(got), 32'(tot));
        n = 0;
        while ((busy || pend_q.size() > 0) && n < BOUND) begin
            @(negedge clk);
            n++;
            if (tx_flag) begin
                if (pend_q.size() == 0) check("r_flag_extra", 32'd1, 32'd0);
                else check("r_flag_data", 32'(tx_data), 32'(pend_q.pop_front()));
            end
        end
        check("r_pending", 32'(pend_q.size()), 32'd0);
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (req_ack != '0) extra++;
        end
        check("r_quiet", 32'(extra), 32'd0);
        model_ptr = last;
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        int          exp_id;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t tbl [8];
    int lat, ac, bad, k;
    int ack_c [5];
    logic [7:0] held;

    initial begin
        // Pointer is 1 when the table starts (after the mid-wait sequence).
        tbl[0] = '{4'b0100, 32'h005A_0000, 2, 8'h5A};
        tbl[1] = '{4'b1001, 32'hC300_003C, 3, 8'hC3};
        tbl[2] = '{4'b1001, 32'hC300_003C, 0, 8'h3C};
        tbl[3] = '{4'b0110, 32'h0081_7E00, 1, 8'h7E};
        tbl[4] = '{4'b0001, 32'h0000_0001, 0, 8'h01};
        tbl[5] = '{4'b1111, 32'hF4E3_D2C1, 1, 8'hD2};
        tbl[6] = '{4'b1100, 32'h9988_0000, 2, 8'h88};
        tbl[7] = '{4'b0011, 32'h0000_ABCD, 0, 8'hCD};

        repeat (2) @(negedge clk);
        check("rst_ack", 32'(req_ack), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_flag", 32'(tx_flag), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gid", 32'(grant_id), 32'd0);

        // All four requesting continuously: 0,1,2,3,0 at a fixed pitch.
        rst = 1'b0;
        req_data = 32'h1312_1110;
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            run_grant($sformatf("all%0d", i), i % 4, 8'(8'h10 + (i % 4)), 1'b0, lat, ack_c[i]);
            if (i > 0) check($sformatf("all%0d_pitch", i), 32'(ack_c[i] - ack_c[i-1]), 32'(PERIOD));
        end
        check("all_lat", 32'(lat), 32'd1);
        req_valid = '0;

        // Requester 1 arrives mid-frame of requester 3; a one-cycle pulse from 0 is ignored.
        req_data = 32'h7700_2155;
        req_valid = 4'b1000;
        lat = 0;
        do begin @(negedge clk); lat++; end while (req_ack == '0 && lat < BOUND);
        check("mid_ack3", 32'(req_ack), 32'h8);
        req_valid = '0;
        repeat (F / 2) @(negedge clk);
        held = tx_data;
        req_valid = 4'b0011;
        @(negedge clk);
        req_valid[0] = 1'b0;
        bad = 0; k = 0;
        while (busy && k < BOUND) begin
            if (req_ack != '0 || tx_data != held) bad++;
            @(negedge clk);
            k++;
        end
        check("mid_hold", 32'(bad), 32'd0);
        check("mid_busy_end", 32'(busy), 32'd0);
        run_grant("mid_ack1", 1, 8'h21, 1'b1, lat, ac);
        check("mid_lat", 32'(lat), 32'd1);

        for (int e = 0; e < 8; e++) begin
            req_data = tbl[e].data;
            req_valid = tbl[e].valid;
            run_grant($sformatf("vec%0d", e), tbl[e].exp_id, tbl[e].exp_byte, 1'b1, lat, ac);
            check($sformatf("vec%0d_lat", e), 32'(lat), 32'd1);
        end
        model_ptr = 0;

        for (int r = 0; r < 6; r++) random_round(r);

        // Asynchronous reset in the middle of a frame.
        req_data = 32'h0000_0042;
        req_valid = 4'b0001;
        lat = 0;
        do begin @(negedge clk); lat++; end while (req_ack == '0 && lat < BOUND);
        check("rst_mid_ack", 32'(req_ack), 32'h1);
        req_valid = '0;
        repeat (30) @(negedge clk);
        req_data = 32'h9300_0090;
        req_valid = 4'b1001;
        #2 rst = 1'b1;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_flag", 32'(tx_flag), 32'd0);
        check("rst_mid_data", 32'(tx_data), 32'd0);
        check("rst_mid_ackz", 32'(req_ack), 32'd0);
        check("rst_mid_gid", 32'(grant_id), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_grant("post_rst0", 0, 8'h90, 1'b0, lat, ac);
        check("post_rst_lat", 32'(lat), 32'd1);
        req_valid[0] = 1'b0;
        run_grant("post_rst3", 3, 8'h93, 1'b1, lat, ac);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #(2_000_000);
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "time limit");
    end

endmodule
